// File: rtl/arcade_input_cond.sv
// Input conditioner for the arcade core's control vector.
// Every bit is debounced. Bits selected by COIN_MASK then go through a coin
// FSM that turns each press into one pulse a fixed number of frames long.
// The block also applies the game's coin lockout and counts accepted coins.
module arcade_input_cond #(
    parameter int unsigned      NBITS       = 8,
    parameter logic [NBITS-1:0] COIN_MASK   = NBITS'(8'h04),
    parameter int unsigned      DEB_CYCLES  = 16,
    parameter int unsigned      COIN_FRAMES = 3,
    parameter int unsigned      GAP_FRAMES  = 2
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             ce_deb,
    input  logic             vblank,
    input  logic             coin_lockout,
    input  logic [NBITS-1:0] raw_in,
    output logic [NBITS-1:0] cond_out,
    output logic [7:0]       coin_count
);

    typedef enum logic [1:0] {
        StIdle,
        StPulse,
        StWaitRel,
        StGap
    } coin_st_e;

    localparam logic [7:0] DEB_LAST  = 8'(DEB_CYCLES - 1);
    localparam logic [3:0] COIN_LOAD = 4'(COIN_FRAMES);
    localparam logic [3:0] GAP_LOAD  = 4'(GAP_FRAMES);

    logic [NBITS-1:0] stable;
    logic [NBITS-1:0] stable_d;
    logic [7:0]       deb_cnt [NBITS];
    logic             vblank_d;
    logic             vb_edge;

    coin_st_e         coin_st  [NBITS];
    logic [3:0]       coin_cnt [NBITS];

    logic [NBITS-1:0] rise;
    logic [NBITS-1:0] enter;
    logic [7:0]       enter_cnt;

    // One tick per frame, taken at the start of vertical blank.
    assign vb_edge = vblank & ~vblank_d;

    // Per-bit debounce: stable follows raw only after DEB_CYCLES consecutive
    // ce_deb ticks of disagreement; one agreeing tick restarts the count.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            stable   <= '0;
            stable_d <= '0;
            vblank_d <= 1'b0;
            for (int i = 0; i < NBITS; i++) begin
                deb_cnt[i] <= 8'd0;
            end
        end else begin
            stable_d <= stable;
            vblank_d <= vblank;
            if (ce_deb) begin
                for (int i = 0; i < NBITS; i++) begin
                    if (raw_in[i] != stable[i]) begin
                        if (deb_cnt[i] == DEB_LAST) begin
                            stable[i]  <= raw_in[i];
                            deb_cnt[i] <= 8'd0;
                        end else begin
                            deb_cnt[i] <= deb_cnt[i] + 8'd1;
                        end
                    end else begin
                        deb_cnt[i] <= 8'd0;
                    end
                end
            end
        end
    end

    // Coin channels arm only on a fresh stable rising edge; an edge that lands
    // under lockout or outside IDLE is lost, so a held coin never re-fires.
    always_comb begin
        rise      = stable & ~stable_d;
        enter     = '0;
        enter_cnt = 8'd0;
        for (int i = 0; i < NBITS; i++) begin
            enter[i]  = COIN_MASK[i] && (coin_st[i] == StIdle) && rise[i] && !coin_lockout;
            enter_cnt = enter_cnt + 8'(enter[i]);
        end
    end

    // Level bits follow stable one clock later; coin bits run the pulse FSM with
    // the output registered alongside the state so both change on the same edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cond_out <= '0;
            for (int i = 0; i < NBITS; i++) begin
                coin_st[i]  <= StIdle;
                coin_cnt[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < NBITS; i++) begin
                if (!COIN_MASK[i]) begin
                    cond_out[i] <= stable[i];
                end else begin
                    unique case (coin_st[i])
                        StIdle: begin
                            if (enter[i]) begin
                                coin_st[i]  <= StPulse;
                                coin_cnt[i] <= COIN_LOAD;
                                cond_out[i] <= 1'b1;
                            end
                        end
                        StPulse: begin
                            // Lockout and stable changes are ignored here so the
                            // pulse length is always COIN_FRAMES.
                            if (vb_edge) begin
                                coin_cnt[i] <= coin_cnt[i] - 4'd1;
                                if (coin_cnt[i] == 4'd1) begin
                                    coin_st[i]  <= StWaitRel;
                                    cond_out[i] <= 1'b0;
                                end
                            end
                        end
                        StWaitRel: begin
                            if (!stable[i]) begin
                                if (GAP_FRAMES == 0) begin
                                    coin_st[i] <= StIdle;
                                end else begin
                                    coin_st[i]  <= StGap;
                                    coin_cnt[i] <= GAP_LOAD;
                                end
                            end
                        end
                        StGap: begin
                            if (vb_edge) begin
                                coin_cnt[i] <= coin_cnt[i] - 4'd1;
                                if (coin_cnt[i] == 4'd1) begin
                                    coin_st[i] <= StIdle;
                                end
                            end
                        end
                        default: begin
                            coin_st[i]  <= StIdle;
                            cond_out[i] <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // Accepted-coin counter; wraps naturally at 8 bits.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            coin_count <= 8'd0;
        end else begin
            coin_count <= coin_count + enter_cnt;
        end
    end

endmodule

// File: tb/tb_arcade_input_cond.sv
// Directed bench for arcade_input_cond with a FIFO scoreboard of expectations.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_arcade_input_cond;

    localparam int FRAME   = 160;
    localparam int VB_LEN  = 16;
    localparam int DEB     = 16;
    localparam int CFRAMES = 3;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       ce_deb;
    logic       vblank;
    logic       coin_lockout;
    logic [7:0] raw_in;
    logic [7:0] cond_out;
    logic [7:0] coin_count;

    arcade_input_cond dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ce_deb      (ce_deb),
        .vblank      (vblank),
        .coin_lockout(coin_lockout),
        .raw_in      (raw_in),
        .cond_out    (cond_out),
        .coin_count  (coin_count)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   passed;
    int   total;
    int   cyc;
    int   exp_coins;
    logic vb_prev;
    logic vbe_next;
    logic vbe_last;
    logic seen;

    // Advance one clock; vbe_last tells whether the edge just taken saw a frame tick.
    task automatic tick();
        @(negedge clk_sys);
        vbe_last = vbe_next;
        cyc++;
        ce_deb   = (cyc % 4 == 0);
        vb_prev  = vblank;
        vblank   = ((cyc % FRAME) >= (FRAME - VB_LEN));
        vbe_next = vblank & ~vb_prev;
    endtask

    task automatic expect_val(string tag, logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty: got %0d, nothing expected", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) begin
            passed++;
        end else begin
            $error("FAIL %s: got %0d expected %0d", e.tag, obs, e.val);
        end
    endtask

    task automatic wait_vbe();
        int guard;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!vbe_last && guard < 2 * FRAME);
        if (!vbe_last) begin
            total++;
            $error("FAIL vblank_wait: got timeout expected frame tick");
        end
    endtask

    task automatic hold_watch(int n, int b, output logic hit);
        hit = 1'b0;
        repeat (n) begin
            tick();
            if (cond_out[b] !== 1'b0) hit = 1'b1;
        end
    endtask

    // Caller has just raised raw_in[b] with stable[b]=0: output must rise exactly
    // one clock after the DEB-th ce_deb edge and not before.
    task automatic deb_rise_check(int b, string tag);
        int   n;
        logic early;
        early = 1'b0;
        expect_val({tag, "_no_early"}, 0);
        expect_val({tag, "_before"}, 0);
        expect_val({tag, "_rise"}, 1);
        n = ce_deb ? 1 : 0;
        while (n < DEB) begin
            tick();
            if (cond_out[b] !== 1'b0) early = 1'b1;
            if (ce_deb) n++;
        end
        tick();
        check(32'(early));
        check(32'(cond_out[b]));
        tick();
        check(32'(cond_out[b]));
    endtask

    // Count frame ticks taken while the coin output was high.
    task automatic measure_pulse(string tag);
        int edges;
        int guard;
        expect_val({tag, "_frames"}, CFRAMES);
        edges = 0;
        guard = 0;
        while (cond_out[2] === 1'b1 && guard < 8 * FRAME) begin
            tick();
            guard++;
            if (vbe_last) edges++;
        end
        check(32'(edges));
    endtask

    task automatic release_and_gap(int frames);
        wait_vbe();
        raw_in[2] = 1'b0;
        repeat (80) tick();
        repeat (frames) wait_vbe();
    endtask

    initial begin
        int n;
        passed       = 0;
        total        = 0;
        cyc          = 0;
        exp_coins    = 0;
        reset_n      = 1'b0;
        ce_deb       = 1'b0;
        vblank       = 1'b0;
        coin_lockout = 1'b0;
        raw_in       = 8'h00;
        vb_prev      = 1'b0;
        vbe_next     = 1'b0;
        vbe_last     = 1'b0;

        repeat (3) tick();
        expect_val("reset_cond", 0);
        expect_val("reset_count", 0);
        check(32'(cond_out));
        check(32'(coin_count));
        reset_n = 1'b1;
        repeat (10) tick();

        // Level channel debounce.
        raw_in[0] = 1'b1;
        deb_rise_check(0, "lvl_press");
        raw_in[0] = 1'b0;
        repeat (80) tick();
        expect_val("lvl_release", 0);
        check(32'(cond_out[0]));

        // Glitch one tick short of the debounce length.
        raw_in[0] = 1'b1;
        n = ce_deb ? 1 : 0;
        while (n < DEB - 1) begin
            tick();
            if (ce_deb) n++;
        end
        tick();
        raw_in[0] = 1'b0;
        expect_val("glitch_ignored", 0);
        hold_watch(100, 0, seen);
        check(32'(seen));
        // Counter must have restarted: a new press needs the full count again.
        raw_in[0] = 1'b1;
        deb_rise_check(0, "lvl_after_glitch");
        raw_in[0] = 1'b0;
        repeat (80) tick();

        // First coin, held for many frames.
        raw_in[2] = 1'b1;
        deb_rise_check(2, "coin1");
        exp_coins++;
        expect_val("coin1_count", exp_coins);
        check(32'(coin_count));
        measure_pulse("coin1");
        expect_val("coin1_no_repeat", 0);
        expect_val("coin1_count_held", exp_coins);
        hold_watch(7 * FRAME, 2, seen);
        check(32'(seen));
        check(32'(coin_count));

        // Re-press one frame after release lands in the gap and is lost.
        release_and_gap(1);
        raw_in[2] = 1'b1;
        expect_val("gap_press_ignored", 0);
        expect_val("gap_press_count", exp_coins);
        hold_watch(2 * FRAME + 40, 2, seen);
        check(32'(seen));
        check(32'(coin_count));

        // Re-press after the gap has expired.
        release_and_gap(3);
        raw_in[2] = 1'b1;
        deb_rise_check(2, "coin2");
        exp_coins++;
        expect_val("coin2_count", exp_coins);
        check(32'(coin_count));
        measure_pulse("coin2");

        // Press under lockout, then lockout lifted while still held.
        release_and_gap(3);
        coin_lockout = 1'b1;
        raw_in[2]    = 1'b1;
        expect_val("lockout_no_pulse", 0);
        expect_val("lockout_count", exp_coins);
        hold_watch(120, 2, seen);
        check(32'(seen));
        check(32'(coin_count));
        coin_lockout = 1'b0;
        expect_val("unlock_held_no_pulse", 0);
        expect_val("unlock_held_count", exp_coins);
        hold_watch(2 * FRAME, 2, seen);
        check(32'(seen));
        check(32'(coin_count));
        raw_in[2] = 1'b0;
        repeat (80) tick();
        raw_in[2] = 1'b1;
        deb_rise_check(2, "coin3");
        exp_coins++;
        expect_val("coin3_count", exp_coins);
        check(32'(coin_count));
        measure_pulse("coin3");

        // Reset in the second frame of a pulse.
        release_and_gap(3);
        raw_in[2] = 1'b1;
        deb_rise_check(2, "coin4");
        exp_coins++;
        expect_val("coin4_count", exp_coins);
        check(32'(coin_count));
        wait_vbe();
        repeat (2) tick();
        expect_val("coin4_mid_high", 1);
        check(32'(cond_out[2]));
        #2 reset_n = 1'b0;
        #1;
        expect_val("async_reset_cond", 0);
        expect_val("async_reset_count", 0);
        check(32'(cond_out));
        check(32'(coin_count));
        repeat (20) tick();
        reset_n   = 1'b1;
        exp_coins = 0;
        deb_rise_check(2, "post_reset");
        exp_coins++;
        expect_val("post_reset_count", exp_coins);
        check(32'(coin_count));
        measure_pulse("post_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
